mux4_scan_driver: RTL and testbench

- Sequential driver/checker that sits directly upstream of the 4:1 mux (`mux4`).
- Accepts a 4-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the mux select through 0..3 and samples the mux output on each step.
- Returns the reassembled word together with a mismatch flag. It lets the mux be exercised in-system and in benches without hand-written stimulus.

---
 rtl/mux4_scan_driver_if.sv | 32 +++
 rtl/mux4_scan_driver.sv | 119 +++++++++++
 tb/tb_mux4_scan_driver.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mux4_scan_driver_if.sv
// Bundle of the word handshake, result handshake and mux-facing bus for
// mux4_scan_driver. The slave modport is the driver's view. The master modport
// is the view of the surrounding environment (word source, result sink and the
// mux producing a).
//
// Handshake semantics (both directions): a transfer happens at a rising clk
// edge where valid and ready are both high. A source holds valid and its data
// stable until that edge. A sink may raise or lower ready freely. in_ready
// depends on driver state only, never combinationally on in_valid.
interface mux4_scan_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] d;
  logic [1:0] s;
  logic       a;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       err;
  logic [1:0] state_dbg;

  modport slave (
    input  in_valid, in_data, out_ready, a,
    output in_ready, d, s, out_valid, out_data, err, state_dbg
  );

  modport master (
    output in_valid, in_data, out_ready, a,
    input  in_ready, d, s, out_valid, out_data, err, state_dbg
  );
endinterface

// File: rtl/mux4_scan_driver.sv
// Scan driver for a 4:1 mux. It accepts a 4-bit word and holds it on the mux
// data inputs. It then walks the select through 0..3 and holds each value for
// DWELL cycles. At the end of each dwell window it samples the mux output. The
// reassembled word is returned with a flag that is set when the word does not
// match what was applied.
module mux4_scan_driver #(
  parameter int DWELL = 1
) (
  input logic              clk,
  input logic              rst,
  mux4_scan_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // The dwell counter runs 0..DWELL-1, so 8 bits cover the full 1..255 range.
  localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] cnt_q;
  logic [3:0] d_q;
  logic [1:0] s_q;
  logic [3:0] capture_q;
  logic       out_valid_q;
  logic [3:0] out_data_q;
  logic       err_q;

  logic       accept;
  logic       window_end;
  logic       last_step;
  logic       release_out;
  logic [3:0] final_word;

  // On the closing edge of the last window, bit 3 comes straight from a.
  // This lets the result register load at the same edge that DONE is entered.
  assign final_word = {bus.a, capture_q[2:0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)      next_state = SCAN;
      SCAN:    if (last_step)   next_state = DONE;
      DONE:    if (release_out) next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // FSM outputs: ready, and the strobes that steer the datapath
  always_comb begin
    bus.in_ready = (state == IDLE);
    accept       = (state == IDLE) && bus.in_valid;
    window_end   = (state == SCAN) && (cnt_q == LAST_CNT);
    last_step    = window_end && (s_q == 2'd3);
    release_out  = (state == DONE) && bus.out_ready;
  end

  // Datapath: applied word, select stepping, dwell timing, capture and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q         <= 4'd0;
      s_q         <= 2'd0;
      cnt_q       <= 8'd0;
      capture_q   <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        d_q       <= bus.in_data;
        s_q       <= 2'd0;
        cnt_q     <= 8'd0;
        capture_q <= 4'd0;
      end else if (state == SCAN) begin
        if (window_end) begin
          capture_q[s_q] <= bus.a;
          cnt_q          <= 8'd0;
          if (s_q != 2'd3) begin
            s_q <= s_q + 2'd1;
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end

      // out_data and d intentionally hold after release; only valid/err drop.
      if (last_step) begin
        out_valid_q <= 1'b1;
        out_data_q  <= final_word;
        err_q       <= (final_word != d_q);
      end else if (release_out) begin
        out_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end
    end
  end

  assign bus.d         = d_q;
  assign bus.s         = s_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_mux4_scan_driver.sv
// Bench for mux4_scan_driver. Two instances are used: DWELL=1 and DWELL=3.
// A shared stimulus set is steered to one of them by sel. The mux in front of
// each DUT is modelled with an optional stuck-at fault on its output.
module tb_mux4_scan_driver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus and steering ----------------
  logic       in_valid  = 1'b0;
  logic [3:0] in_data   = 4'd0;
  logic       out_ready = 1'b0;
  logic       sel       = 1'b0;   // 0: DWELL=1 instance, 1: DWELL=3 instance
  int         fault     = 0;      // 0: good mux, 1: a stuck at 0, 2: a stuck at 1

  mux4_scan_driver_if if1 ();
  mux4_scan_driver_if if3 ();

  assign if1.in_valid  = in_valid & ~sel;
  assign if3.in_valid  = in_valid & sel;
  assign if1.in_data   = in_data;
  assign if3.in_data   = in_data;
  assign if1.out_ready = out_ready & ~sel;
  assign if3.out_ready = out_ready & sel;
  assign if1.a = (fault == 0) ? if1.d[if1.s] : (fault == 2);
  assign if3.a = (fault == 0) ? if3.d[if3.s] : (fault == 2);

  mux4_scan_driver #(.DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  mux4_scan_driver #(.DWELL(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  wire       o_in_ready  = sel ? if3.in_ready  : if1.in_ready;
  wire [3:0] o_d         = sel ? if3.d         : if1.d;
  wire [1:0] o_s         = sel ? if3.s         : if1.s;
  wire       o_out_valid = sel ? if3.out_valid : if1.out_valid;
  wire [3:0] o_out_data  = sel ? if3.out_data  : if1.out_data;
  wire       o_err       = sel ? if3.err       : if1.err;

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];   // {err, out_data} expected per accepted word
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver task ----------------
  // Applies one word and walks the scan cycle by cycle against the rules:
  // s = (k-1)/N in cycle k of the scan, and the result appears in cycle 4N+1.
  // The result is held for `hold` cycles before it is released.
  task automatic run_word(input logic [3:0] word, input int fmode, input int hold,
                          input bit busy_push);
    int n;
    int guard;
    logic [3:0] exp_data;
    logic [4:0] exp;
    n = sel ? 3 : 1;
    fault = fmode;
    for (int i = 0; i < 4; i++)
      exp_data[i] = (fmode == 0) ? word[i] : (fmode == 2);
    exp_q.push_back({exp_data != word, exp_data});

    guard = 0;
    while (!o_in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("ready_before_accept", o_in_ready, 1);

    in_data  = word;
    in_valid = 1'b1;
    tick();                                 // accept edge is cycle 0
    if (busy_push) in_data = 4'b0101;       // keep offering a word while busy
    else in_valid = 1'b0;

    for (int k = 0; k < 4 * n; k++) begin
      check("scan_s", o_s, k / n);
      check("scan_d", o_d, word);
      check("scan_in_ready", o_in_ready, 0);
      check("scan_out_valid", o_out_valid, 0);
      tick();
    end

    check("done_out_valid", o_out_valid, 1);
    exp = exp_q.pop_front();
    check("result", {o_err, o_out_data}, exp);

    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_out_valid", o_out_valid, 1);
      check("hold_in_ready", o_in_ready, 0);
      check("hold_result", {o_err, o_out_data}, exp);
      check("hold_d", o_d, word);
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_out_valid", o_out_valid, 0);
    check("release_in_ready", o_in_ready, 1);
    check("release_d", o_d, word);
    check("release_s", o_s, 3);
    check("release_out_data", o_out_data, exp_data);
    check("release_err", o_err, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check("rst_d", o_d, 0);
      check("rst_s", o_s, 0);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_out_data", o_out_data, 0);
      check("rst_err", o_err, 0);
    end
    sel = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("idle_in_ready", o_in_ready, 1);

    // basic scan, good mux
    run_word(4'b0111, 0, 0, 1'b0);
    // fault detection: stuck at 0, stuck at 1
    run_word(4'b1010, 1, 0, 1'b0);
    run_word(4'b1010, 2, 0, 1'b0);
    // dwell timing with DWELL=3
    sel = 1'b1;
    run_word(4'b1001, 0, 0, 1'b0);
    // backpressure and busy on the DWELL=1 instance
    sel = 1'b0;
    run_word(4'b1100, 0, 5, 1'b1);

    // reset mid-scan
    fault    = 0;
    in_data  = 4'b1111;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_d", o_d, 0);
    check("abort_s", o_s, 0);
    check("abort_out_valid", o_out_valid, 0);
    check("abort_out_data", o_out_data, 0);
    check("abort_err", o_err, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_result", o_out_valid, 0);
    end
    run_word(4'b0011, 0, 0, 1'b0);

    // randomized words, faults, instances and hold times
    for (int r = 0; r < 30; r++) begin
      sel = 1'($urandom_range(0, 1));
      run_word(4'($urandom_range(0, 15)), $urandom_range(0, 2),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("queue_empty", 8'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
